// File: rtl/sub_bytes_serial.sv
// sub_bytes_serial: iterative AES SubBytes layer.
// A 128-bit state is accepted over valid/ready, LANES bytes are substituted
// per cycle through LANES shared S-box lookups, and the finished state is
// held on out_bytes until the downstream ShiftRows layer takes it.
// Optional feature macro: SUBBYTES_INV_EN adds an 'inv' input that selects
// the inverse S-box for the decryption datapath.
module sub_bytes_serial #(
  parameter int LANES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_bytes,
`ifdef SUBBYTES_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_bytes
);

  localparam int STEPS = 16 / LANES;
  localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(STEPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 forward S-box; element [0] is the leftmost byte.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUBBYTES_INV_EN
  // FIPS-197 inverse S-box.
  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_next;
  logic [IDXW-1:0] idx, idx_next;
  logic [127:0]    work, work_next;
  logic            inv_q, inv_next;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];

  // Gather the LANES bytes addressed by idx from the working register.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = work[127 - 8 * (int'(idx) * LANES + l) -: 8];
    end
  end

  // One S-box lookup per lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
`ifdef SUBBYTES_INV_EN
    assign lane_out[g] = inv_q ? SBOX_INV[lane_in[g]] : SBOX_FWD[lane_in[g]];
`else
    assign lane_out[g] = SBOX_FWD[lane_in[g]];
`endif
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_next = state;
    idx_next   = idx;
    work_next  = work;
    inv_next   = inv_q;
    in_ready   = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          work_next[127 - 8 * (int'(idx) * LANES + l) -: 8] = lane_out[l];
        end
        if (idx == LAST_IDX) begin
          idx_next   = '0;
          state_next = DONE;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Acceptance from IDLE, or back-to-back from DONE.
    if (in_valid && in_ready) begin
      work_next  = in_bytes;
      idx_next   = '0;
`ifdef SUBBYTES_INV_EN
      inv_next   = inv;
`else
      inv_next   = 1'b0;
`endif
      state_next = BUSY;
    end
  end

  // State, index and working register; reset discards any in-flight state.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      work  <= '0;
      inv_q <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      work  <= work_next;
      inv_q <= inv_next;
    end
  end

  assign out_valid = (state == DONE);
  assign out_bytes = work;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Testbench for sub_bytes_serial: scoreboard of expected states filled at
// acceptance, drained by an output monitor. Reference S-box is derived from
// GF(2^8) inversion plus the AES affine map.
module tb_sub_bytes_serial;

  localparam int LANES = 4;
  localparam int STEPS = 16 / LANES;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_bytes = '0;
  logic         inv_drv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_bytes;

  sub_bytes_serial #(.LANES(LANES)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bytes(in_bytes),
`ifdef SUBBYTES_INV_EN
    .inv(inv_drv),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_bytes(out_bytes)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  logic [127:0] exp_q[$];
  int           acc_q[$];
  bit           seen_rise = 0;
  bit           b2b_phase = 0;
  int           b2b_n = 0;
  int           last_xfer = 0;
  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // ---- reference model ----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);   // a^254 = a^-1, 0 -> 0
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic iv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[127 - 8 * i -: 8] = iv ? inv_tab[d[127 - 8 * i -: 8]] : fwd_tab[d[127 - 8 * i -: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---- driver: hold in_valid until accepted, then record expectation ----
  task automatic send(input logic [127:0] d, input logic iv, input logic [127:0] req,
                      input bit push, output int n);
    bit acc = 0;
    n = 0;
    in_valid = 1'b1;
    in_bytes = d;
    inv_drv  = iv;
    do begin
      #1 acc = in_ready;
      @(posedge clock);
      n++;
    end while (!acc && n < 100);
    check(acc, "accept_timeout", 128'(n), 128'(1));
    @(negedge clock);
    in_valid = 1'b0;
    if (push && acc) begin
      exp_q.push_back(req);
      acc_q.push_back(cyc_cnt);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clock);
      w++;
    end
    check(exp_q.size() == 0, "drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  // ---- monitor ----
  always @(negedge clock) begin
    #2;
    if (reset) begin
      seen_rise = 0;
    end else if (out_valid) begin
      check(exp_q.size() != 0, "unexpected_output", out_bytes, 128'(0));
      if (exp_q.size() != 0) begin
        if (!seen_rise) begin
          check(cyc_cnt - acc_q[0] == STEPS, "latency", 128'(cyc_cnt - acc_q[0]), 128'(STEPS));
          seen_rise = 1;
        end
        if (out_ready) begin
          check(out_bytes === exp_q[0], "out_bytes", out_bytes, exp_q[0]);
          if (b2b_phase) begin
            if (b2b_n > 0)
              check(cyc_cnt - last_xfer == STEPS + 1, "b2b_period",
                    128'(cyc_cnt - last_xfer), 128'(STEPS + 1));
            b2b_n++;
            last_xfer = cyc_cnt;
          end
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          seen_rise = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- stimulus ----
  initial begin
    int n;
    logic [127:0] d, bp_exp;
    int w;

    for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_math(8'(i));
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

    repeat (3) @(negedge clock);
    #1;
    check(out_valid == 1'b0, "reset_out_valid", 128'(out_valid), 128'(0));
    check(in_ready == 1'b1, "reset_in_ready", 128'(in_ready), 128'(1));
    check(out_bytes == 128'h0, "reset_out_bytes", out_bytes, 128'h0);
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;

    // Known-answer state
    send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
         128'hd42711aee0bf98f1b8b45de51e415230, 1, n);
    drain();
    #1;
    check(in_ready == 1'b1 && out_valid == 1'b0, "idle_after_xfer",
          128'({in_ready, out_valid}), 128'(2'b10));
    @(negedge clock);

    // Byte edge values
    send({16{8'h00}}, 1'b0, {16{8'h63}}, 1, n);
    send({16{8'hff}}, 1'b0, {16{8'h16}}, 1, n);
    send({16{8'h53}}, 1'b0, {16{8'hed}}, 1, n);
    drain();

    // Backpressure
    out_ready = 1'b0;
    d = rand128();
    bp_exp = model(d, 1'b0);
    send(d, 1'b0, bp_exp, 1, n);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clock);
      w++;
    end
    check(out_valid == 1'b1, "bp_out_valid", 128'(out_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      check(out_bytes == bp_exp && out_valid, "bp_hold", out_bytes, bp_exp);
      check(in_ready == 1'b0, "bp_in_ready", 128'(in_ready), 128'(0));
    end
    @(negedge clock);
    out_ready = 1'b1;
    d = rand128();
    send(d, 1'b0, model(d, 1'b0), 1, n);
    check(n == 1, "bp_same_cycle_accept", 128'(n), 128'(1));
    drain();

    // Back-to-back
    b2b_phase = 1;
    for (int i = 0; i < 8; i++) begin
      d = rand128();
      send(d, 1'b0, model(d, 1'b0), 1, n);
    end
    drain();
    b2b_phase = 0;
    check(b2b_n == 8, "b2b_count", 128'(b2b_n), 128'(8));

    // Reset mid-operation: this state must never appear
    @(negedge clock);
    send(rand128(), 1'b0, 128'h0, 0, n);
    if (STEPS > 1) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check(out_valid == 1'b0, "rst_mid_out_valid", 128'(out_valid), 128'(0));
    check(in_ready == 1'b1, "rst_mid_in_ready", 128'(in_ready), 128'(1));
    check(out_bytes == 128'h0, "rst_mid_out_bytes", out_bytes, 128'h0);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    d = rand128();
    send(d, 1'b0, model(d, 1'b0), 1, n);
    drain();

`ifdef SUBBYTES_INV_EN
    send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
         128'h193de3bea0f4e22b9ac68d2ae9f84808, 1, n);
    send({16{8'h63}}, 1'b1, {16{8'h00}}, 1, n);
    for (int i = 0; i < 4; i++) begin
      d = rand128();
      send(d, i[0], model(d, i[0]), 1, n);
    end
    drain();
`endif

    // A few random states with random downstream stalls
    for (int i = 0; i < 6; i++) begin
      d = rand128();
      send(d, 1'b0, model(d, 1'b0), 1, n);
      out_ready = 1'b0;
      repeat ($urandom_range(STEPS + 3, 0)) @(negedge clock);
      out_ready = 1'b1;
    end
    drain();

    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
